// File: rtl/card_punch_pkg.sv
// Shared constants and types for the card punch: geometry, blank encodings and FSM states.
package card_punch_pkg;

    localparam int ROWS   = 15;
    localparam int DIGITS = 5;
    localparam int CARDS  = 4;
    localparam int ROW_W  = 4 * DIGITS;

    localparam logic [3:0]       BLANK_NIB = 4'hF;
    localparam logic [ROW_W-1:0] BLANK_ROW = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PUNCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Codes A..E are not decimal digits; F is the legitimate blank marker.
    function automatic logic is_bad_bcd(input logic [3:0] d);
        return (d >= 4'hA) && (d <= 4'hE);
    endfunction

endpackage

// File: rtl/card_row_packer.sv
// Packs accepted digits MS-nibble first into one row; emits the merged row and a write strobe
// on the digit that closes the row.
module card_row_packer
    import card_punch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             accept,
    input  logic [3:0]       dig,
    input  logic             dig_last,
    input  logic             dig_eoc,
    output logic [ROW_W-1:0] row_data,
    output logic             row_wr
);

    localparam int CNT_W = $clog2(DIGITS);

    logic [ROW_W-1:0] pack_reg;
    logic [CNT_W-1:0] nib_cnt_reg;

    // Incoming digit overlays the nibble selected by nib_cnt; other nibbles keep the pack value.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            localparam logic [CNT_W-1:0] POS = CNT_W'(DIGITS - 1 - gi);
            assign row_data[4*gi +: 4] = (nib_cnt_reg == POS) ? dig : pack_reg[4*gi +: 4];
        end
    endgenerate

    assign row_wr = accept && ((nib_cnt_reg == CNT_W'(DIGITS - 1)) || dig_last || dig_eoc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_reg    <= BLANK_ROW;
            nib_cnt_reg <= '0;
        end else if (clear || row_wr) begin
            pack_reg    <= BLANK_ROW;
            nib_cnt_reg <= '0;
        end else if (accept) begin
            pack_reg    <= row_data;
            nib_cnt_reg <= nib_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/card_punch.sv
// Card punch top: FSM, row counter, per-slot row storage with valid bits, combinational read.
// Optional BCD validation is enabled by defining CARD_PUNCH_BCD_CHECK_EN.
module card_punch
    import card_punch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       card_slt,
    input  logic             dig_valid,
    output logic             dig_ready,
    input  logic [3:0]       dig_in,
    input  logic             dig_last,
    input  logic             dig_eoc,
    output logic             busy,
    output logic             done,
    output logic             card_full,
    output logic             err_digit,
    input  logic [1:0]       rd_slt,
    input  logic [3:0]       rd_addr,
    output logic [ROW_W-1:0] rd_data
);

    localparam int MEM_AW    = $clog2(CARDS * ROWS);
    localparam int MEM_DEPTH = 2 ** MEM_AW;

    state_t           state_reg, state_next;
    logic [1:0]       slot_reg;
    logic [3:0]       row_cnt_reg;
    logic             card_full_reg;
    logic [ROWS-1:0]  valid_reg [CARDS];
    logic [ROW_W-1:0] mem [MEM_DEPTH];

    logic             start_fire;
    logic             accept;
    logic [3:0]       dig_store;
    logic [ROW_W-1:0] row_data;
    logic             row_wr;
    logic             row_full_hit;
    logic             card_end;
    logic [MEM_AW-1:0] wr_idx;
    logic [MEM_AW-1:0] rd_idx;
    logic [ROWS:0]    rd_valid_pad;

    assign start_fire   = start && (state_reg == IDLE);
    assign accept       = dig_valid && dig_ready;
    assign row_full_hit = row_wr && (row_cnt_reg == 4'(ROWS - 1));
    assign card_end     = accept && (dig_eoc || row_full_hit);

`ifdef CARD_PUNCH_BCD_CHECK_EN
    logic err_digit_reg;

    assign dig_store = is_bad_bcd(dig_in) ? BLANK_NIB : dig_in;
    assign err_digit = err_digit_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_digit_reg <= 1'b0;
        end else if (start_fire) begin
            err_digit_reg <= 1'b0;
        end else if (accept && is_bad_bcd(dig_in)) begin
            err_digit_reg <= 1'b1;
        end
    end
`else
    assign dig_store = dig_in;
    assign err_digit = 1'b0;
`endif

    card_row_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_fire),
        .accept   (accept),
        .dig      (dig_store),
        .dig_last (dig_last),
        .dig_eoc  (dig_eoc),
        .row_data (row_data),
        .row_wr   (row_wr)
    );

    always_comb begin
        state_next = state_reg;
        dig_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = PUNCH;
            end
            PUNCH: begin
                dig_ready = 1'b1;
                busy      = 1'b1;
                if (card_end) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            slot_reg      <= '0;
            row_cnt_reg   <= '0;
            card_full_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_fire) begin
                slot_reg      <= card_slt;
                row_cnt_reg   <= '0;
                card_full_reg <= 1'b0;
            end else if (row_wr) begin
                row_cnt_reg <= row_cnt_reg + 1'b1;
                if (row_full_hit) card_full_reg <= 1'b1;
            end
        end
    end

    assign card_full = card_full_reg;

    // Valid bits decide what reads back; the row RAM itself needs no reset.
    generate
        for (genvar gi = 0; gi < CARDS; gi++) begin : g_slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= '0;
                end else if (start_fire && (card_slt == 2'(gi))) begin
                    valid_reg[gi] <= '0;
                end else if (row_wr && (slot_reg == 2'(gi))) begin
                    valid_reg[gi][row_cnt_reg] <= 1'b1;
                end
            end
        end
    endgenerate

    assign wr_idx = MEM_AW'(slot_reg) * MEM_AW'(ROWS) + MEM_AW'(row_cnt_reg);
    assign rd_idx = MEM_AW'(rd_slt) * MEM_AW'(ROWS) + MEM_AW'(rd_addr);

    always_ff @(posedge clk) begin
        if (row_wr) mem[wr_idx] <= row_data;
    end

    assign rd_valid_pad = {1'b0, valid_reg[rd_slt]};
    assign rd_data = ((rd_addr < 4'(ROWS)) && rd_valid_pad[rd_addr]) ? mem[rd_idx] : BLANK_ROW;

endmodule

// File: tb/tb_card_punch.sv
// Self-checking bench for card_punch: directed cards, a read-back vector table, randomized
// gapped streams against a digit-list reference model, and mid-card reset.
module tb_card_punch;
    import card_punch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  card_slt;
    logic        dig_valid;
    logic        dig_ready;
    logic [3:0]  dig_in;
    logic        dig_last;
    logic        dig_eoc;
    logic        busy;
    logic        done;
    logic        card_full;
    logic        err_digit;
    logic [1:0]  rd_slt;
    logic [3:0]  rd_addr;
    logic [19:0] rd_data;

    int checks = 0;
    int failures = 0;

    card_punch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .card_slt  (card_slt),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .dig_in    (dig_in),
        .dig_last  (dig_last),
        .dig_eoc   (dig_eoc),
        .busy      (busy),
        .done      (done),
        .card_full (card_full),
        .err_digit (err_digit),
        .rd_slt    (rd_slt),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: each card is a list of digits; a row is closed after 5 digits, on
    // last, or on eoc, and written left-justified with F padding.
    logic [19:0] m_rows [4][15];
    int          m_slot;
    int          m_row;
    logic [3:0]  m_cur[$];
    bit          m_done, m_full, m_err;

    function automatic void m_clear_all();
        for (int s = 0; s < 4; s++)
            for (int r = 0; r < 15; r++) m_rows[s][r] = 20'hFFFFF;
    endfunction

    function automatic void m_start(input int s);
        for (int r = 0; r < 15; r++) m_rows[s][r] = 20'hFFFFF;
        m_slot = s; m_row = 0; m_cur.delete();
        m_done = 0; m_full = 0; m_err = 0;
    endfunction

    function automatic void m_accept(input logic [3:0] d, input bit last, input bit eoc);
        logic [3:0]  v;
        logic [19:0] r;
        v = d;
`ifdef CARD_PUNCH_BCD_CHECK_EN
        if (d >= 4'hA && d <= 4'hE) begin v = 4'hF; m_err = 1; end
`endif
        m_cur.push_back(v);
        if (m_cur.size() == 5 || last || eoc) begin
            r = 20'hFFFFF;
            for (int i = 0; i < m_cur.size(); i++) r[19-4*i -: 4] = m_cur[i];
            m_rows[m_slot][m_row] = r;
            m_row++;
            m_cur.delete();
        end
        if (m_row == 15) m_full = 1;
        if (eoc || m_row == 15) m_done = 1;
    endfunction

    logic [3:0] s_dig[$];
    bit         s_last[$];
    bit         s_eoc[$];

    task automatic clear_stream();
        s_dig.delete(); s_last.delete(); s_eoc.delete();
    endtask

    task automatic push(input logic [3:0] d, input bit last, input bit eoc);
        s_dig.push_back(d); s_last.push_back(last); s_eoc.push_back(eoc);
    endtask

    task automatic do_start(input int s);
        start = 1'b1; card_slt = 2'(s);
        @(posedge clk); #1;
        start = 1'b0;
        m_start(s);
        chk("start_ready", dig_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_full_clr", card_full, 0);
        chk("start_err_clr", err_digit, 0);
        $display("start slot=%0d", s);
    endtask

    task automatic run_stream(input int gap_pct, input int start_at,
                              output int acc_n, output int cyc_n);
        int idx;
        bit acc;
        idx = 0; acc_n = 0; cyc_n = 0;
        while (idx < s_dig.size() && !m_done && cyc_n < 3000) begin
            start     = (cyc_n == start_at);
            card_slt  = 2'd3;
            dig_valid = !(gap_pct > 0 && $urandom_range(99) < gap_pct);
            dig_in    = s_dig[idx];
            dig_last  = s_last[idx];
            dig_eoc   = s_eoc[idx];
            @(negedge clk);
            acc = dig_valid && dig_ready;
            @(posedge clk); #1;
            cyc_n++;
            if (acc) begin
                m_accept(s_dig[idx], s_last[idx], s_eoc[idx]);
                idx++; acc_n++;
            end
            chk("done_timing", done, m_done);
            chk("ready_in_punch", dig_ready, !m_done);
        end
        start = 1'b0;
        if (!m_done) dig_valid = 1'b0;
        chk("stream_no_timeout", cyc_n < 3000, 1);
        $display("stream accepts=%0d cycles=%0d", acc_n, cyc_n);
    endtask

    task automatic finish_card();
        chk("done_ready_low", dig_ready, 0);
        chk("done_busy", busy, 1);
        chk("card_full", card_full, m_full);
        chk("err_digit", err_digit, m_err);
        dig_valid = 1'b1; dig_in = 4'h7; dig_last = 1'b0; dig_eoc = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_busy_low", busy, 0);
        chk("idle_ready_low", dig_ready, 0);
        dig_valid = 1'b0;
    endtask

    task automatic check_rows(input string tag);
        for (int s = 0; s < 4; s++) begin
            for (int r = 0; r < 16; r++) begin
                rd_slt = 2'(s); rd_addr = 4'(r);
                #1;
                chk($sformatf("%s_s%0d_r%0d", tag, s, r), rd_data,
                    (r < 15) ? m_rows[s][r] : 20'hFFFFF);
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  slt;
        logic [3:0]  addr;
        logic [19:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tab[11];

    initial begin
        int acc_n, cyc_n;

        rd_tab[0]  = '{2'd1, 4'd0,  20'h2535F};
        rd_tab[1]  = '{2'd1, 4'd1,  20'hFFFFF};
        rd_tab[2]  = '{2'd1, 4'd14, 20'hFFFFF};
        rd_tab[3]  = '{2'd2, 4'd0,  20'h12345};
        rd_tab[4]  = '{2'd2, 4'd1,  20'h67890};
        rd_tab[5]  = '{2'd2, 4'd2,  20'hFFFFF};
        rd_tab[6]  = '{2'd3, 4'd0,  20'h77777};
        rd_tab[7]  = '{2'd3, 4'd14, 20'h77777};
        rd_tab[8]  = '{2'd3, 4'd15, 20'hFFFFF};
        rd_tab[9]  = '{2'd0, 4'd0,  20'hFFFFF};
        rd_tab[10] = '{2'd2, 4'd15, 20'hFFFFF};

        rst_n = 1'b0; start = 1'b0; card_slt = 2'd0; dig_valid = 1'b0;
        dig_in = 4'h0; dig_last = 1'b0; dig_eoc = 1'b0; rd_slt = 2'd0; rd_addr = 4'd0;
        m_clear_all();
        m_start(0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", dig_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_full", card_full, 0);
        chk("rst_err", err_digit, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_rows("reset");

        // Short card: one partial row.
        do_start(1);
        clear_stream();
        push(4'd2, 0, 0); push(4'd5, 0, 0); push(4'd3, 0, 0); push(4'd5, 1, 1);
        run_stream(0, -1, acc_n, cyc_n);
        chk("t1_accepts", acc_n, 4);
        finish_card();
        check_rows("t1");

        // Continuous digits: two rows, full throughput.
        do_start(2);
        clear_stream();
        for (int i = 1; i <= 10; i++) push(4'(i % 10), 0, i == 10);
        run_stream(0, -1, acc_n, cyc_n);
        chk("t2_accepts", acc_n, 10);
        chk("t2_cycles", cyc_n, 10);
        finish_card();
        check_rows("t2");

        // Overflowing card: ends on the 75th digit by filling all rows.
        do_start(3);
        clear_stream();
        for (int i = 0; i < 80; i++) push(4'd7, 0, 0);
        run_stream(0, -1, acc_n, cyc_n);
        chk("t3_accepts", acc_n, 75);
        chk("t3_full_now", card_full, 1);
        finish_card();
        check_rows("t3");

        for (int i = 0; i < 11; i++) begin
            rd_slt = rd_tab[i].slt; rd_addr = rd_tab[i].addr;
            #1;
            chk($sformatf("table_%0d", i), rd_data, rd_tab[i].exp);
            $display("read slot=%0d addr=%0d data=%h", rd_tab[i].slt, rd_tab[i].addr, rd_data);
        end
        @(posedge clk); #1;

        // Random gaps plus a stray start aimed at slot 3.
        for (int rep = 0; rep < 3; rep++) begin
            do_start(0);
            clear_stream();
            for (int i = 0; i < 23; i++)
                push(4'($urandom_range(9)), $urandom_range(99) < 20, i == 22);
            run_stream(30, 3 + rep, acc_n, cyc_n);
            finish_card();
            check_rows($sformatf("t4_%0d", rep));
        end

        // Non-decimal digit.
        do_start(0);
        clear_stream();
        push(4'hC, 0, 0); push(4'h1, 0, 1);
        run_stream(0, -1, acc_n, cyc_n);
`ifdef CARD_PUNCH_BCD_CHECK_EN
        chk("t5_err", err_digit, 1);
        rd_slt = 2'd0; rd_addr = 4'd0; #1;
        chk("t5_row0", rd_data, 20'hF1FFF);
`else
        chk("t5_err", err_digit, 0);
        rd_slt = 2'd0; rd_addr = 4'd0; #1;
        chk("t5_row0", rd_data, 20'hC1FFF);
`endif
        finish_card();
        do_start(1);
        clear_stream();
        push(4'h4, 0, 1);
        run_stream(0, -1, acc_n, cyc_n);
        finish_card();
        check_rows("t5");

        // Reset in the middle of a card after three rows.
        do_start(2);
        clear_stream();
        for (int i = 0; i < 15; i++) push(4'($urandom_range(9)), 0, 0);
        run_stream(0, -1, acc_n, cyc_n);
        chk("t6_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy_rst", busy, 0);
        chk("t6_ready_rst", dig_ready, 0);
        m_clear_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_rows("t6_rst");
        do_start(0);
        clear_stream();
        push(4'd3, 0, 0); push(4'd1, 0, 0); push(4'd4, 0, 1);
        run_stream(0, -1, acc_n, cyc_n);
        finish_card();
        check_rows("t6_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
